// File: rtl/bep_frame_check_if.sv
// Signal bundle between the serial field decoder / readout logic and the BEP frame checker.
// The checker is the slave: it consumes strobes and decoder fields and drives the result registers.
interface bep_frame_check_if;
    logic        transmission_begin;
    logic        bit_strobe;
    logic [31:0] preamble;
    logic [31:0] constant;
    logic [31:0] thermostat_id;
    logic [15:0] type_1;
    logic [15:0] type_2;
    logic [15:0] room_temp;
    logic [15:0] set_temp;
    logic [7:0]  state;
    logic [7:0]  tail_1;
    logic [7:0]  tail_2;
    logic [7:0]  tail_3;
    logic        busy;
    logic        frame_valid;
    logic        frame_error;
    logic [2:0]  error_code;
    logic [31:0] id_out;
    logic [15:0] room_out;
    logic [15:0] set_out;
    logic [7:0]  state_out;
    logic [7:0]  good_count;
    logic [7:0]  bad_count;

    modport master (
        output transmission_begin, bit_strobe, preamble, constant, thermostat_id,
               type_1, type_2, room_temp, set_temp, state, tail_1, tail_2, tail_3,
        input  busy, frame_valid, frame_error, error_code, id_out, room_out, set_out,
               state_out, good_count, bad_count
    );

    modport slave (
        input  transmission_begin, bit_strobe, preamble, constant, thermostat_id,
               type_1, type_2, room_temp, set_temp, state, tail_1, tail_2, tail_3,
        output busy, frame_valid, frame_error, error_code, id_out, room_out, set_out,
               state_out, good_count, bad_count
    );
endinterface

// File: rtl/bep_frame_check.sv
// BEP frame checker: counts decoded bits, lets the decoder fields settle, validates framing
// and latches payload of good frames with one-cycle good/bad strobes and saturating counters.
module bep_frame_check #(
    parameter int          FRAME_BITS     = 192,
    parameter logic [31:0] PREAMBLE       = 32'hFFFF_FFFE,
    parameter logic [31:0] CONSTANT       = 32'h0000_0001,
    parameter logic [23:0] TAIL           = 24'h00_00_00,
    parameter int          TIMEOUT_CYCLES = 20000
) (
    input logic              clk,
    input logic              rst_n,
    bep_frame_check_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECEIVE, SETTLE, REPORT} fsm_state_t;

    localparam logic [2:0] ERR_TRUNCATED = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd6;

    fsm_state_t  state_q, state_d;
    logic [7:0]  bit_cnt;
    logic [15:0] idle_timer;
    logic [2:0]  result_code;
    logic [2:0]  check_code;
    logic        restart_pending;
    logic        last_strobe;
    logic        timed_out;

    assign last_strobe = bus.bit_strobe && (bit_cnt == 8'(FRAME_BITS - 1));
    assign timed_out   = !bus.bit_strobe && (idle_timer == 16'(TIMEOUT_CYCLES - 1));

    // Framing check, lowest error code wins.
    always_comb begin
        check_code = 3'd0;
        if (bus.preamble != PREAMBLE)                               check_code = 3'd1;
        else if (bus.type_1 != bus.type_2)                          check_code = 3'd2;
        else if (bus.constant != CONSTANT)                          check_code = 3'd3;
        else if ({bus.tail_1, bus.tail_2, bus.tail_3} != TAIL)      check_code = 3'd4;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.transmission_begin) state_d = RECEIVE;
            RECEIVE: begin
                if (bus.transmission_begin) state_d = RECEIVE;
                else if (last_strobe)       state_d = SETTLE;
                else if (timed_out)         state_d = REPORT;
            end
            SETTLE:  state_d = REPORT;
            REPORT:  state_d = (restart_pending || bus.transmission_begin) ? RECEIVE : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt         <= '0;
            idle_timer      <= '0;
            result_code     <= '0;
            restart_pending <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.error_code  <= '0;
            bus.id_out      <= '0;
            bus.room_out    <= '0;
            bus.set_out     <= '0;
            bus.state_out   <= '0;
            bus.good_count  <= '0;
            bus.bad_count   <= '0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.busy        <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    bit_cnt    <= '0;
                    idle_timer <= '0;
                end
                RECEIVE: begin
                    if (bus.transmission_begin) begin
                        // Aborted frame is reported immediately; the new frame starts from zero.
                        bit_cnt         <= '0;
                        idle_timer      <= '0;
                        bus.frame_error <= 1'b1;
                        bus.error_code  <= ERR_TRUNCATED;
                        if (bus.bad_count != 8'hFF) bus.bad_count <= bus.bad_count + 8'd1;
                    end else if (bus.bit_strobe) begin
                        bit_cnt    <= bit_cnt + 8'd1;
                        idle_timer <= '0;
                    end else begin
                        idle_timer <= idle_timer + 16'd1;
                        if (timed_out) result_code <= ERR_TIMEOUT;
                    end
                end
                SETTLE: begin
                    result_code <= check_code;
                    if (bus.transmission_begin) restart_pending <= 1'b1;
                end
                REPORT: begin
                    restart_pending <= 1'b0;
                    bit_cnt         <= '0;
                    idle_timer      <= '0;
                    if (result_code == 3'd0) begin
                        bus.frame_valid <= 1'b1;
                        bus.id_out      <= bus.thermostat_id;
                        bus.room_out    <= bus.room_temp;
                        bus.set_out     <= bus.set_temp;
                        bus.state_out   <= bus.state;
                        if (bus.good_count != 8'hFF) bus.good_count <= bus.good_count + 8'd1;
                    end else begin
                        bus.frame_error <= 1'b1;
                        bus.error_code  <= result_code;
                        if (bus.bad_count != 8'hFF) bus.bad_count <= bus.bad_count + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bep_frame_check.sv
// Self-checking bench for bep_frame_check: directed scenarios plus random frames checked
// against a frame-level reference model (expected code, latched payload, saturating counts).
module tb_bep_frame_check;
    localparam int          FRAME_BITS = 192;
    localparam int          TIMEOUT    = 20000;
    localparam logic [31:0] PRE        = 32'hFFFF_FFFE;
    localparam logic [31:0] CONST      = 32'h0000_0001;
    localparam logic [23:0] TAILV      = 24'h00_00_00;

    typedef struct {
        logic [31:0] pre, cons, id;
        logic [15:0] t1, t2, room, set;
        logic [7:0]  st, tl1, tl2, tl3;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bep_frame_check_if bus();

    bep_frame_check #(
        .FRAME_BITS(FRAME_BITS), .PREAMBLE(PRE), .CONSTANT(CONST),
        .TAIL(TAILV), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int     checks = 0;
    int     errors = 0;
    int     exp_good = 0;
    int     exp_bad = 0;
    logic [2:0] exp_code = '0;
    frame_t exp_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t zero_frame();
        frame_t f;
        f = '{pre: '0, cons: '0, id: '0, t1: '0, t2: '0, room: '0, set: '0,
              st: '0, tl1: '0, tl2: '0, tl3: '0};
        return f;
    endfunction

    function automatic frame_t good_frame();
        frame_t f;
        f = '{pre: PRE, cons: CONST, id: $urandom(), t1: 16'($urandom()), t2: '0,
              room: 16'($urandom()), set: 16'($urandom()), st: 8'($urandom()),
              tl1: TAILV[23:16], tl2: TAILV[15:8], tl3: TAILV[7:0]};
        f.t2 = f.t1;
        return f;
    endfunction

    // Each framing field is independently corrupted with probability 1/3.
    function automatic frame_t rand_frame();
        frame_t f;
        f = good_frame();
        if ($urandom_range(0, 2) == 0) f.pre  ^= ($urandom() | 32'h1);
        if ($urandom_range(0, 2) == 0) f.t2   ^= (16'($urandom()) | 16'h1);
        if ($urandom_range(0, 2) == 0) f.cons ^= ($urandom() | 32'h1);
        if ($urandom_range(0, 2) == 0) f.tl2  ^= (8'($urandom()) | 8'h1);
        return f;
    endfunction

    function automatic logic [2:0] ref_code(input frame_t f);
        if (f.pre != PRE)                  return 3'd1;
        if (f.t1 != f.t2)                  return 3'd2;
        if (f.cons != CONST)               return 3'd3;
        if ({f.tl1, f.tl2, f.tl3} != TAILV) return 3'd4;
        return 3'd0;
    endfunction

    task automatic model_reset();
        exp_good = 0;
        exp_bad  = 0;
        exp_code = '0;
        exp_lat  = zero_frame();
    endtask

    task automatic model_report(input logic [2:0] code, input frame_t f);
        if (code == 3'd0) begin
            exp_good = (exp_good < 255) ? exp_good + 1 : 255;
            exp_lat  = f;
        end else begin
            exp_bad  = (exp_bad < 255) ? exp_bad + 1 : 255;
            exp_code = code;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_code"},  32'(bus.error_code), 32'(exp_code));
        check({tag, "_good"},  32'(bus.good_count), 32'(exp_good));
        check({tag, "_bad"},   32'(bus.bad_count),  32'(exp_bad));
        check({tag, "_id"},    bus.id_out,          exp_lat.id);
        check({tag, "_room"},  32'(bus.room_out),   32'(exp_lat.room));
        check({tag, "_set"},   32'(bus.set_out),    32'(exp_lat.set));
        check({tag, "_state"}, 32'(bus.state_out),  32'(exp_lat.st));
    endtask

    task automatic load_fields(input frame_t f);
        bus.preamble      = f.pre;
        bus.constant      = f.cons;
        bus.thermostat_id = f.id;
        bus.type_1        = f.t1;
        bus.type_2        = f.t2;
        bus.room_temp     = f.room;
        bus.set_temp      = f.set;
        bus.state         = f.st;
        bus.tail_1        = f.tl1;
        bus.tail_2        = f.tl2;
        bus.tail_3        = f.tl3;
    endtask

    task automatic pulse_begin(input logic with_strobe);
        bus.transmission_begin = 1'b1;
        bus.bit_strobe         = with_strobe;
        tick();
        bus.transmission_begin = 1'b0;
        bus.bit_strobe         = 1'b0;
    endtask

    // Strobes with random gaps; no result pulse may appear while bits are arriving.
    task automatic send_bits(input int n);
        logic spurious;
        spurious = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                spurious |= bus.frame_valid | bus.frame_error;
            end
            bus.bit_strobe = 1'b1;
            tick();
            bus.bit_strobe = 1'b0;
            spurious |= bus.frame_valid | bus.frame_error;
        end
        check("no_pulse_during_rx", 32'(spurious), 32'd0);
    endtask

    // Called right after the edge that took the final strobe; result is due two edges later.
    task automatic expect_report(input string tag, input frame_t f, input logic begin_in_settle);
        logic [2:0] code;
        bus.transmission_begin = begin_in_settle;
        tick();
        bus.transmission_begin = 1'b0;
        check({tag, "_early"}, 32'(bus.frame_valid | bus.frame_error), 32'd0);
        check({tag, "_busy_settle"}, 32'(bus.busy), 32'd1);
        tick();
        code = ref_code(f);
        model_report(code, f);
        check({tag, "_valid"}, 32'(bus.frame_valid), 32'(code == 3'd0));
        check({tag, "_error"}, 32'(bus.frame_error), 32'(code != 3'd0));
        check({tag, "_busy_after"}, 32'(bus.busy), 32'(begin_in_settle));
        check_outputs(tag);
        tick();
        check({tag, "_one_cycle"}, 32'(bus.frame_valid | bus.frame_error), 32'd0);
    endtask

    initial begin
        frame_t f;
        logic   early, busy_drop;

        bus.transmission_begin = 1'b0;
        bus.bit_strobe         = 1'b0;
        load_fields(zero_frame());
        model_reset();

        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pulses", 32'(bus.frame_valid | bus.frame_error), 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed good frame; the strobe coinciding with begin must not be counted.
        f = '{pre: PRE, cons: CONST, id: 32'hDEADBEEF, t1: 16'h1234, t2: 16'h1234,
              room: 16'h00D2, set: 16'h00C8, st: 8'h03, tl1: 8'h00, tl2: 8'h00, tl3: 8'h00};
        load_fields(f);
        pulse_begin(1'b1);
        send_bits(FRAME_BITS);
        expect_report("good", f, 1'b0);

        // Type mismatch plus bad tail: type error has priority.
        f.t2  = 16'h1235;
        f.tl3 = 8'h5A;
        load_fields(f);
        pulse_begin(1'b0);
        send_bits(FRAME_BITS);
        expect_report("type_tail", f, 1'b0);

        // Timeout after 100 bits.
        pulse_begin(1'b0);
        send_bits(100);
        early = 1'b0;
        busy_drop = 1'b0;
        repeat (TIMEOUT) begin
            tick();
            early     |= bus.frame_valid | bus.frame_error;
            busy_drop |= ~bus.busy;
        end
        check("timeout_early", 32'(early), 32'd0);
        check("timeout_busy_held", 32'(busy_drop), 32'd0);
        tick();
        model_report(3'd6, f);
        check("timeout_error", 32'(bus.frame_error), 32'd1);
        check("timeout_valid", 32'(bus.frame_valid), 32'd0);
        check("timeout_busy", 32'(bus.busy), 32'd0);
        check_outputs("timeout");

        // Restart after 50 bits, then a complete good frame.
        f = good_frame();
        load_fields(f);
        pulse_begin(1'b0);
        send_bits(50);
        pulse_begin(1'b0);
        model_report(3'd5, f);
        check("abort_error", 32'(bus.frame_error), 32'd1);
        check("abort_valid", 32'(bus.frame_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd1);
        check_outputs("abort");
        send_bits(FRAME_BITS);
        expect_report("after_abort", f, 1'b0);

        // Begin during SETTLE: report completes, then a fresh frame starts without another begin.
        f = rand_frame();
        load_fields(f);
        pulse_begin(1'b0);
        send_bits(FRAME_BITS);
        expect_report("settle_begin", f, 1'b1);
        f = rand_frame();
        load_fields(f);
        send_bits(FRAME_BITS);
        expect_report("chained", f, 1'b0);

        for (int n = 0; n < 16; n++) begin
            f = rand_frame();
            load_fields(f);
            pulse_begin(1'b0);
            send_bits(FRAME_BITS);
            expect_report("random", f, 1'b0);
        end

        // Asynchronous reset at strobe 120.
        f = good_frame();
        load_fields(f);
        pulse_begin(1'b0);
        send_bits(119);
        bus.bit_strobe = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        bus.bit_strobe = 1'b0;
        model_reset();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_pulses", 32'(bus.frame_valid | bus.frame_error), 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        send_bits(FRAME_BITS + 4);
        tick();
        tick();
        check("ignored_busy", 32'(bus.busy), 32'd0);
        check_outputs("ignored");

        // Saturation: 259 aborts plus one bad full frame, then a good frame.
        pulse_begin(1'b0);
        early = 1'b0;
        for (int n = 0; n < 259; n++) begin
            bus.bit_strobe = 1'b1;
            tick();
            bus.bit_strobe = 1'b0;
            pulse_begin(1'b0);
            model_report(3'd5, f);
            early |= ~bus.frame_error;
        end
        check("sat_abort_pulses", 32'(early), 32'd0);
        f = good_frame();
        f.cons = 32'h0000_0002;
        load_fields(f);
        send_bits(FRAME_BITS);
        expect_report("sat_bad", f, 1'b0);
        check("sat_bad_is_255", 32'(bus.bad_count), 32'd255);
        f = good_frame();
        load_fields(f);
        pulse_begin(1'b0);
        send_bits(FRAME_BITS);
        expect_report("sat_good", f, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bep_frame_check.md
# bep_frame_check

Frame checker that sits directly downstream of the serial field decoder in the BEP thermostat receive path. It counts decoded bit strobes from the Manchester stage, waits for the serial decoder's field registers to settle once a full frame has arrived, and validates the framing fields (preamble, duplicated type, constant, tail). Payload fields from good frames are latched into stable output registers, with one-cycle good/bad strobes and saturating statistics counters for the display/readout logic.

## Interface
Parameters:
- `FRAME_BITS`, 192, bit strobes per complete frame (sum of all decoder field widths)
- `PREAMBLE`, 32'hFFFF_FFFE, required preamble value
- `CONSTANT`, 32'h0000_0001, required constant field value
- `TAIL`, 24'h00_00_00, required {tail_1, tail_2, tail_3}
- `TIMEOUT_CYCLES`, 20000, max clk cycles between bit strobes inside a frame (< 65536)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `transmission_begin`  in  1  one-cycle pulse, start of a new frame (same pulse that resets the serial decoder)
- `bit_strobe`  in  1  one-cycle pulse per decoded bit (Manchester clock)
- `preamble`, `constant`, `thermostat_id`  in  32 each  decoder fields
- `type_1`, `type_2`, `room_temp`, `set_temp`  in  16 each  decoder fields
- `state`, `tail_1`, `tail_2`, `tail_3`  in  8 each  decoder fields
- `busy`  out  1  high in RECEIVE, SETTLE, REPORT
- `frame_valid`  out  1  one-cycle pulse, good frame latched
- `frame_error`  out  1  one-cycle pulse, frame rejected
- `error_code`  out  3  cause of last rejection, held until next rejection
- `id_out`  out  32  thermostat_id of last good frame
- `room_out`, `set_out`  out  16 each  room_temp / set_temp of last good frame
- `state_out`  out  8  state of last good frame
- `good_count`, `bad_count`  out  8 each  saturating frame counters

## Operation
- States: IDLE, RECEIVE, SETTLE, REPORT. Internal: 8-bit bit counter, 16-bit idle timer, registered check result.
- IDLE: bit strobes ignored. `transmission_begin` -> RECEIVE, bit counter = 0, timer = 0.
- RECEIVE: each strobe increments the bit counter and clears the timer. Without a strobe, the timer increments.
  - On the strobe that brings the count to `FRAME_BITS` -> SETTLE.
  - Timer reaching `TIMEOUT_CYCLES` -> REPORT with error 6.
  - `transmission_begin` -> counts the aborted frame as error 5, then restarts RECEIVE at count 0. `frame_error` pulses in the next cycle; no REPORT state is used for this case.
- SETTLE (1 cycle): the decoder fields are now stable. Compare them and register the result, then -> REPORT.
- Error priority (lowest code wins): 1 preamble≠`PREAMBLE`; 2 type_1≠type_2; 3 constant≠`CONSTANT`; 4 tails≠`TAIL`; 0 = good. Codes 5 = truncated/restart, 6 = timeout.
- REPORT (1 cycle): pulse `frame_valid` or `frame_error` -> IDLE.
  - Good frame: update `id_out`, `room_out`, `set_out`, `state_out` and increment `good_count`.
  - Bad frame: update `error_code` and increment `bad_count`.
  - Counters saturate at 255.
- `transmission_begin` during SETTLE/REPORT: the current frame completes its report normally, then the block goes to RECEIVE at count 0 instead of IDLE. The begin pulse is remembered in a 1-bit flag.
- Strobes in SETTLE/REPORT are ignored.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0 (including latched fields, counters, `error_code`), `busy` 0.
- Final strobe at edge N -> SETTLE during N+1 -> `frame_valid`/`frame_error` and updated outputs visible after edge N+2. Latency 2 cycles.
- A strobe in the same cycle as `transmission_begin` is not counted; that bit is also dropped by the decoder.
- Timeout: `TIMEOUT_CYCLES` consecutive strobe-free cycles in RECEIVE -> `frame_error` asserted on the following cycle.
- `frame_valid` and `frame_error` are never high together; each is exactly one cycle.
- All outputs are registered.
- Latched fields are never partially updated.

## Test plan
- Good frame: preamble FFFF_FFFE, type 1234/1234, constant 1, id 0xDEADBEEF, room 0x00D2, set 0x00C8, state 0x03, tails 0, with 192 strobes -> `frame_valid` 2 cycles after the last strobe; `id_out`=DEADBEEF, `room_out`=00D2, `set_out`=00C8, `good_count`=1.
- Type mismatch (type_2=1235) and also bad tail -> `frame_error`, `error_code`=2 (priority), `bad_count`=1, latched fields unchanged.
- 100 strobes then a 20000-cycle gap -> `frame_error`, `error_code`=6, state IDLE, `busy` 0.
- New `transmission_begin` after 50 strobes, then a good frame -> first `error_code`=5, then `frame_valid`; counters good=1, bad=1.
- 260 bad frames -> `bad_count` holds 255; then one good frame -> `good_count`=1.
- `rst_n` low mid-frame (strobe 120) -> all outputs 0 immediately. Strobes after release are ignored until `transmission_begin`.
